sram_port_arbiter: RTL and testbench

Two-requester controller that shares one single-port SRAM macro (din0/dout0/addr0/csb0/web0/clk0) between two clients. It arbitrates round-robin, drives registered SRAM control/address/data, and pipelines read data back to the originating requester. Optionally it zero-fills the array after reset. It sits directly in front of the SRAM macro and replaces hand-driven stimulus of the macro pins.

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_rr_arb.sv | 32 +++
 rtl/sram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for controllers that put a single-port SRAM macro behind an arbiter.
package sram_arb_pkg;

  localparam int unsigned WORD_SIZE_DEF = 8;
  localparam int unsigned NUM_WORDS_DEF = 16;
  localparam int unsigned ADDR_W_DEF    = $clog2(NUM_WORDS_DEF);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Tag carried alongside an SRAM access until its read data returns
  typedef struct packed {
    logic is_read;
    logic id;
  } tag_t;

  typedef struct packed {
    logic                     we;
    logic [ADDR_W_DEF-1:0]    addr;
    logic [WORD_SIZE_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is issued.
module sram_rr_arb (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_q;

  // On contention the requester that was not granted last wins
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two requesters with registered macro pins.
// Define SRAM_ARB_INIT_EN to zero-fill the array after reset before accepting requests.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter  int unsigned NUM_WORDS = NUM_WORDS_DEF,
  localparam int unsigned ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                 clk0,
  input  logic                 rstb0,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [WORD_SIZE-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [WORD_SIZE-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [WORD_SIZE-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [WORD_SIZE-1:0] rsp1_rdata,
  output logic                 sram_csb0,
  output logic                 sram_web0,
  output logic [ADDR_W-1:0]    sram_addr0,
  output logic [WORD_SIZE-1:0] sram_din0,
  input  logic [WORD_SIZE-1:0] sram_dout0,
  output logic                 init_done
);

`ifdef SRAM_ARB_INIT_EN
  localparam state_t RESET_STATE = INIT;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t               state_q, state_d;
  logic [1:0]           grant;
  logic                 accept;
  logic                 sel;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                 csb_d, web_d, done_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [WORD_SIZE-1:0] din_d;
  tag_t                 tag_d, pipe1_q, pipe2_q;

  sram_rr_arb u_arb (
    .clk   (clk0),
    .rstb  (rstb0),
    .en    (state_q == RUN),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel        = grant[1];
  assign sel_we     = sel ? req1_we    : req0_we;
  assign sel_addr   = sel ? req1_addr  : req0_addr;
  assign sel_wdata  = sel ? req1_wdata : req0_wdata;

  // Next state and next values of the registered macro pins
  always_comb begin
    state_d = state_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = '0;
    din_d   = '0;
    tag_d   = '0;
`ifdef SRAM_ARB_INIT_EN
    init_addr_d = init_addr_q;
`endif
    case (state_q)
      INIT: begin
`ifdef SRAM_ARB_INIT_EN
        csb_d       = 1'b0;
        web_d       = 1'b0;
        addr_d      = init_addr_q;
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == ADDR_W'(NUM_WORDS - 1)) begin
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        if (accept) begin
          csb_d         = 1'b0;
          web_d         = ~sel_we;
          addr_d        = sel_addr;
          din_d         = sel_wdata;
          tag_d.is_read = ~sel_we;
          tag_d.id      = sel;
        end
      end
    endcase
    done_d = (state_d == RUN);
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SRAM_ARB_INIT_EN
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      init_addr_q <= '0;
    end else begin
      init_addr_q <= init_addr_d;
    end
  end
`endif

  // Macro pins, two-stage read tag pipe and response capture at the tag's third edge
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      pipe1_q    <= '0;
      pipe2_q    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
      init_done  <= (RESET_STATE == RUN);
    end else begin
      sram_csb0  <= csb_d;
      sram_web0  <= web_d;
      sram_addr0 <= addr_d;
      sram_din0  <= din_d;
      pipe1_q    <= tag_d;
      pipe2_q    <= pipe1_q;
      init_done  <= done_d;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (pipe2_q.is_read) begin
        if (pipe2_q.id) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= sram_dout0;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= sram_dout0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro and reference model.
// Honours SRAM_ARB_INIT_EN the same way the design does.
module tb_sram_port_arbiter;

  localparam int unsigned WS = 8;
  localparam int unsigned NW = 16;
  localparam int unsigned AW = 4;

`ifdef SRAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
  } op_t;

  typedef struct {
    logic          id;
    logic [WS-1:0] data;
    int            due;
  } pend_t;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          rstb0;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [WS-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [WS-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [WS-1:0] rsp0_rdata, rsp1_rdata;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [WS-1:0] sram_din0, sram_dout0;
  logic          init_done;

  sram_port_arbiter #(.WORD_SIZE(WS), .NUM_WORDS(NW)) dut (
    .clk0       (clk0),
    .rstb0      (rstb0),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .init_done  (init_done)
  );

  // Single-port macro: samples its pins on the edge after the arbiter drives them
  logic [WS-1:0] mem [NW];
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0      <= mem[sram_addr0];
    end
  end

  int rsp0_pulses = 0;
  int rsp1_pulses = 0;
  always @(negedge clk0) begin
    if (rsp0_valid === 1'b1) rsp0_pulses++;
    if (rsp1_valid === 1'b1) rsp1_pulses++;
  end

  // Reference model state
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            armed    = 1'b0;
  logic          last;
  logic [WS-1:0] ref_mem [NW];
  logic [WS-1:0] exp_rdata [2];
  logic          exp_csb, exp_web, exp_done;
  logic [AW-1:0] exp_addr;
  logic [WS-1:0] exp_din;
  int            init_left;
  pend_t         pend [$];
  op_t           q0 [$];
  op_t           q1 [$];
  int            grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic pins_idle();
    exp_csb  = 1'b1;
    exp_web  = 1'b1;
    exp_addr = '0;
    exp_din  = '0;
  endtask

  task automatic model_reset();
    pend.delete();
    last         = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    pins_idle();
    init_left = INIT_EN ? NW : 0;
    exp_done  = !INIT_EN;
  endtask

  // One clock: check outputs at the falling edge, predict the next edge, then advance
  task automatic step(output logic [1:0] acc);
    pend_t      p;
    logic [1:0] v, g, exp_v;
    logic       id;
    acc = 2'b00;
    @(negedge clk0);
    if (armed) begin
      exp_v = 2'b00;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        exp_v[p.id] = 1'b1;
        exp_rdata[p.id] = p.data;
      end
      chk("rsp0_valid", 32'(rsp0_valid), 32'(exp_v[0]));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(exp_v[1]));
      chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rdata[0]));
      chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rdata[1]));
      chk("sram_csb0", 32'(sram_csb0), 32'(exp_csb));
      chk("sram_web0", 32'(sram_web0), 32'(exp_web));
      chk("sram_addr0", 32'(sram_addr0), 32'(exp_addr));
      chk("sram_din0", 32'(sram_din0), 32'(exp_din));
      chk("init_done", 32'(init_done), 32'(exp_done));

      v = {req1_valid, req0_valid};
      g = 2'b00;
      if (init_left == 0) begin
        if (v == 2'b11) g = last ? 2'b01 : 2'b10;
        else            g = v;
      end
      chk("req0_ready", 32'(req0_ready), 32'(g[0]));
      chk("req1_ready", 32'(req1_ready), 32'(g[1]));
      acc = g;

      if (!rstb0) begin
        pins_idle();
      end else if (init_left > 0) begin
        exp_csb  = 1'b0;
        exp_web  = 1'b0;
        exp_addr = AW'(NW - init_left);
        exp_din  = '0;
        ref_mem[NW - init_left] = '0;
        init_left--;
        if (init_left == 0) exp_done = 1'b1;
      end else if (g != 2'b00) begin
        id   = g[1];
        last = id;
        grant_log.push_back(int'(id));
        exp_csb  = 1'b0;
        exp_web  = ~(id ? req1_we : req0_we);
        exp_addr = id ? req1_addr : req0_addr;
        exp_din  = id ? req1_wdata : req0_wdata;
        if (!exp_web) ref_mem[exp_addr] = exp_din;
        else          pend.push_back('{id: id, data: ref_mem[exp_addr], due: cyc + 3});
      end else begin
        pins_idle();
      end
    end
    @(posedge clk0);
    cyc++;
    if (!rstb0) begin
      armed = 1'b1;
      model_reset();
    end
    #1;
  endtask

  task automatic run(input int n);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  // Present queue heads until both queues empty; optional random valid gaps
  task automatic drain(input bit idle_rand, input int budget);
    logic [1:0] acc;
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      req0_valid = (q0.size() > 0) && !(idle_rand && $urandom_range(3, 0) == 0);
      req1_valid = (q1.size() > 0) && !(idle_rand && $urandom_range(3, 0) == 0);
      if (q0.size() > 0) begin
        req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].data;
      end
      if (q1.size() > 0) begin
        req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].data;
      end
      step(acc);
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      n++;
    end
    n_assert++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_budget: observed=%0d/%0d ops left expected=0/0", q0.size(), q1.size());
    end
    drive_idle();
  endtask

  function automatic op_t mk(input logic we, input int addr, input int data);
    op_t o;
    o.we   = we;
    o.addr = AW'(addr);
    o.data = WS'(data);
    return o;
  endfunction

  task automatic shuffle(output int perm [NW]);
    int j, t;
    for (int i = 0; i < NW; i++) perm[i] = i;
    for (int i = NW - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rstb0 = 1'b0;
    run(2);
    rstb0 = 1'b1;
  endtask

  initial begin
    int perm [NW];
    int pulses;
    logic [1:0] acc;

    drive_idle();
    rstb0 = 1'b0;
    run(3);
    rstb0 = 1'b1;
    chk("reset_csb0", 32'(sram_csb0), 32'd1);
    chk("reset_init_done", 32'(init_done), 32'(!INIT_EN));
    chk("reset_rsp0_rdata", 32'(rsp0_rdata), 32'd0);

    // Write then read on requester 0
    q0.push_back(mk(1'b1, 3, 'hA5));
    q0.push_back(mk(1'b0, 3, 0));
    drain(1'b0, 200);
    run(4);
    chk("t1_rsp0_rdata", 32'(rsp0_rdata), 32'hA5);
    chk("t1_rsp1_pulses", 32'(rsp1_pulses), 32'd0);

    // Both continuously valid: strict alternation starting with requester 0
    do_reset();
    grant_log.delete();
    q0.push_back(mk(1'b1, 1, 'h11));
    q0.push_back(mk(1'b0, 1, 0));
    q1.push_back(mk(1'b1, 2, 'h22));
    q1.push_back(mk(1'b0, 2, 0));
    drain(1'b0, 200);
    run(4);
    chk("t2_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    chk("t2_rsp0_rdata", 32'(rsp0_rdata), 32'h11);
    chk("t2_rsp1_rdata", 32'(rsp1_rdata), 32'h22);

    // Read immediately after write to the same address
    q0.push_back(mk(1'b1, 7, 'h3C));
    q0.push_back(mk(1'b0, 7, 0));
    drain(1'b0, 50);
    run(4);
    chk("t3_rsp0_rdata", 32'(rsp0_rdata), 32'h3C);

    // Fill every address in shuffled order, read back shuffled across both requesters
    shuffle(perm);
    for (int i = 0; i < NW; i++) begin
      if ($urandom_range(1, 0) == 0) q0.push_back(mk(1'b1, perm[i], int'($urandom_range(255, 0))));
      else                           q1.push_back(mk(1'b1, perm[i], int'($urandom_range(255, 0))));
    end
    drain(1'b0, 200);
    shuffle(perm);
    for (int i = 0; i < NW; i++) begin
      if ($urandom_range(1, 0) == 0) q0.push_back(mk(1'b0, perm[i], 0));
      else                           q1.push_back(mk(1'b0, perm[i], 0));
    end
    drain(1'b0, 200);
    run(4);
    chk("t4_pending", 32'(pend.size()), 32'd0);

    // Random mixed traffic with valid gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1, 0) == 0)
        q0.push_back(mk(1'($urandom_range(1, 0)), int'($urandom_range(NW - 1, 0)), int'($urandom_range(255, 0))));
      else
        q1.push_back(mk(1'($urandom_range(1, 0)), int'($urandom_range(NW - 1, 0)), int'($urandom_range(255, 0))));
    end
    drain(1'b1, 2000);
    run(4);
    chk("t5_pending", 32'(pend.size()), 32'd0);

    // Reset one cycle after a read accept drops the read
    q0.push_back(mk(1'b0, 5, 0));
    drain(1'b0, 50);
    pulses = rsp0_pulses + rsp1_pulses;
    rstb0 = 1'b0;
    step(acc);
    rstb0 = 1'b1;
    run(NW + 4);
    chk("t6_no_rsp_after_reset", 32'(rsp0_pulses + rsp1_pulses), 32'(pulses));
    chk("t6_csb0_idle", 32'(sram_csb0), 32'd1);
    chk("t6_web0_idle", 32'(sram_web0), 32'd1);
    chk("t6_addr0_idle", 32'(sram_addr0), 32'd0);
    chk("t6_din0_idle", 32'(sram_din0), 32'd0);

`ifdef SRAM_ARB_INIT_EN
    // Zero fill: no ready for NUM_WORDS cycles, then every word reads back as zero
    drive_idle();
    rstb0 = 1'b0;
    step(acc);
    rstb0 = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk0);
      chk("t7_ready_during_init", 32'({req1_ready, req0_ready}), 32'd0);
      chk("t7_init_done_low", 32'(init_done), 32'd0);
      @(posedge clk0);
      cyc++;
      #1;
    end
    chk("t7_init_done_high", 32'(init_done), 32'd1);
    drive_idle();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    init_left = 0;
    exp_done  = 1'b1;
    exp_csb   = 1'b0;
    exp_web   = 1'b0;
    exp_addr  = AW'(NW - 1);
    exp_din   = '0;
    for (int i = 0; i < NW; i++) begin
      if (i % 2 == 0) q0.push_back(mk(1'b0, i, 0));
      else            q1.push_back(mk(1'b0, i, 0));
    end
    drain(1'b0, 200);
    run(4);
    chk("t7_rsp0_zero", 32'(rsp0_rdata), 32'd0);
    chk("t7_rsp1_zero", 32'(rsp1_rdata), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
